te_packet_decoder: RTL and testbench

//  Receive side of the trace encoder's packet stream. Accepts framed trace packets byte by byte,

---
 rtl/te_packet_decoder_if.sv | 31 +++
 rtl/te_packet_decoder.sv | 125 ++++++++++++
 tb/tb_te_packet_decoder.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/te_packet_decoder_if.sv
// Byte-stream input and decoded-packet output of the trace packet decoder.
// master = environment (drives bytes, consumes packets); slave = decoder.
interface te_packet_decoder_if #(
    parameter int XLEN              = 32,
    parameter int MAX_PAYLOAD_BYTES = 16
);
    logic                           byte_valid;
    logic [7:0]                     byte_data;
    logic                           byte_ready;
    logic                           pkt_valid;
    logic                           pkt_ready;
    logic [4:0]                     pkt_len;
    logic [1:0]                     pkt_format;
    logic [1:0]                     pkt_subformat;
    logic [1:0]                     pkt_priv;
    logic [XLEN-1:0]                pkt_addr;
    logic [8*MAX_PAYLOAD_BYTES-1:0] pkt_payload;
    logic                           err;

    modport master (
        output byte_valid, byte_data, pkt_ready,
        input  byte_ready, pkt_valid, pkt_len, pkt_format, pkt_subformat,
               pkt_priv, pkt_addr, pkt_payload, err
    );

    modport slave (
        input  byte_valid, byte_data, pkt_ready,
        output byte_ready, pkt_valid, pkt_len, pkt_format, pkt_subformat,
               pkt_priv, pkt_addr, pkt_payload, err
    );
endinterface

// File: rtl/te_packet_decoder.sv
// Reassembles framed trace packets ({rsvd,len} header + len bytes, LSB first) and decodes fields.
// pkt_valid rises the cycle after the last payload byte; no bytes are taken while a packet is held.
module te_packet_decoder #(
    parameter int XLEN              = 32,
    parameter int MAX_PAYLOAD_BYTES = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    te_packet_decoder_if.slave   bus
);
    localparam int         PW      = 8 * MAX_PAYLOAD_BYTES;
    localparam logic [4:0] MAX_LEN = 5'(MAX_PAYLOAD_BYTES);

    typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_DISCARD, S_OUT} state_e;

    state_e          state_q;
    logic [4:0]      count_q, len_q;
    logic [PW-1:0]   payload_q;
    logic            pkt_valid_q, err_q;
    logic [1:0]      fmt_q, sub_q, priv_q;
    logic [XLEN-1:0] addr_q;

    logic            accept;
    logic [4:0]      hdr_len;
    logic [PW-1:0]   payload_d;
    logic [1:0]      fmt_d, sub_d, priv_d;
    logic [XLEN-1:0] addr_d;

    assign accept  = bus.byte_valid && (state_q != S_OUT);
    assign hdr_len = bus.byte_data[4:0];

    // Decode from the payload as it will look once the current byte is written,
    // so fields are registered together with pkt_valid.
    always_comb begin
        payload_d = payload_q;
        for (int i = 0; i < MAX_PAYLOAD_BYTES; i++) begin
            if (count_q == 5'(i)) payload_d[i*8 +: 8] = bus.byte_data;
        end
        fmt_d  = payload_d[1:0];
        sub_d  = 2'd0;
        priv_d = 2'd0;
        addr_d = '0;
        case (fmt_d)
            2'd3: begin
                sub_d = payload_d[3:2];
                if (sub_d == 2'd0 || sub_d == 2'd1) priv_d = payload_d[6:5];
                if (sub_d == 2'd0) addr_d = payload_d[7 +: XLEN];
            end
            2'd0:    sub_d  = {1'b0, payload_d[2]};
            2'd2:    addr_d = payload_d[2 +: XLEN];
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            len_q       <= '0;
            payload_q   <= '0;
            pkt_valid_q <= 1'b0;
            err_q       <= 1'b0;
            fmt_q       <= '0;
            sub_q       <= '0;
            priv_q      <= '0;
            addr_q      <= '0;
        end else begin
            err_q <= 1'b0;
            if (flush_i) begin
                state_q     <= S_IDLE;
                count_q     <= '0;
                pkt_valid_q <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: if (accept) begin
                        if (hdr_len == 5'd0) begin
                            err_q <= 1'b1;
                        end else if (hdr_len > MAX_LEN) begin
                            err_q   <= 1'b1;
                            count_q <= hdr_len;
                            state_q <= S_DISCARD;
                        end else begin
                            len_q     <= hdr_len;
                            payload_q <= '0;
                            count_q   <= '0;
                            state_q   <= S_PAYLOAD;
                        end
                    end
                    S_PAYLOAD: if (accept) begin
                        payload_q <= payload_d;
                        count_q   <= count_q + 5'd1;
                        if (count_q + 5'd1 == len_q) begin
                            state_q     <= S_OUT;
                            pkt_valid_q <= 1'b1;
                            fmt_q       <= fmt_d;
                            sub_q       <= sub_d;
                            priv_q      <= priv_d;
                            addr_q      <= addr_d;
                        end
                    end
                    S_DISCARD: if (accept) begin
                        count_q <= count_q - 5'd1;
                        if (count_q == 5'd1) state_q <= S_IDLE;
                    end
                    S_OUT: if (bus.pkt_ready) begin
                        state_q     <= S_IDLE;
                        pkt_valid_q <= 1'b0;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.byte_ready    = (state_q != S_OUT);
    assign bus.pkt_valid     = pkt_valid_q;
    assign bus.pkt_len       = len_q;
    assign bus.pkt_format    = fmt_q;
    assign bus.pkt_subformat = sub_q;
    assign bus.pkt_priv      = priv_q;
    assign bus.pkt_addr      = addr_q;
    assign bus.pkt_payload   = payload_q;
    assign bus.err           = err_q;
endmodule

// File: tb/tb_te_packet_decoder.sv
// Directed bench for te_packet_decoder: framing, field decode, backpressure, errors and flush.
module tb_te_packet_decoder;
    localparam int XLEN = 32;
    localparam int MAXB = 16;

    logic clk;
    logic rst_n;
    logic flush;
    int   checks = 0;
    int   errors = 0;
    int   err_seen = 0;
    int   pkt_rise = 0;
    logic pv_prev = 1'b0;

    te_packet_decoder_if #(.XLEN(XLEN), .MAX_PAYLOAD_BYTES(MAXB)) bus ();

    te_packet_decoder #(.XLEN(XLEN), .MAX_PAYLOAD_BYTES(MAXB)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .flush_i(flush),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.err === 1'b1) err_seen++;
        if (bus.pkt_valid === 1'b1 && !pv_prev) pkt_rise++;
        pv_prev = (bus.pkt_valid === 1'b1);
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Presents one byte, waits (bounded) for ready, returns #1 after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        while (bus.byte_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("byte_ready_timeout", 128'(n), 128'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic end_bytes();
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
    endtask

    task automatic take_pkt(input string tag);
        bus.pkt_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.pkt_ready = 1'b0;
        chk({tag, "_valid_drop"}, 128'(bus.pkt_valid), 128'(0));
        chk({tag, "_ready_back"}, 128'(bus.byte_ready), 128'(1));
    endtask

    task automatic chk_fields(input string tag, input logic [4:0] len, input logic [1:0] fmt,
                              input logic [1:0] sub, input logic [1:0] priv, input logic [31:0] addr);
        chk({tag, "_valid"}, 128'(bus.pkt_valid), 128'(1));
        chk({tag, "_len"},   128'(bus.pkt_len), 128'(len));
        chk({tag, "_fmt"},   128'(bus.pkt_format), 128'(fmt));
        chk({tag, "_sub"},   128'(bus.pkt_subformat), 128'(sub));
        chk({tag, "_priv"},  128'(bus.pkt_priv), 128'(priv));
        chk({tag, "_addr"},  128'(bus.pkt_addr), 128'(addr));
    endtask

    int e0;
    int p0;

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        bus.pkt_ready  = 1'b0;
        #23;
        chk("rst_pkt_valid", 128'(bus.pkt_valid), 128'(0));
        chk("rst_err", 128'(bus.err), 128'(0));
        chk("rst_byte_ready", 128'(bus.byte_ready), 128'(1));
        chk("rst_payload", 128'(bus.pkt_payload), 128'(0));
        chk("rst_addr", 128'(bus.pkt_addr), 128'(0));
        chk("rst_len", 128'(bus.pkt_len), 128'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // SF_START: payload 73 80 00 00 40 -> addr = 0x40_0000_8073 >> 7
        e0 = err_seen;
        send_byte(8'h05);
        chk("start_no_early_valid", 128'(bus.pkt_valid), 128'(0));
        send_byte(8'h73); send_byte(8'h80); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h40);
        end_bytes();
        chk_fields("start", 5'd5, 2'd3, 2'd0, 2'd3, 32'h8000_0100);
        chk("start_payload", 128'(bus.pkt_payload), 128'h40_0000_8073);
        chk("start_no_err", 128'(err_seen - e0), 128'(0));

        // Backpressure: hold the packet for 5 cycles while a byte is offered
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'h01;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            chk("bp_byte_ready", 128'(bus.byte_ready), 128'(0));
            chk_fields("bp", 5'd5, 2'd3, 2'd0, 2'd3, 32'h8000_0100);
        end
        end_bytes();
        take_pkt("start");

        // OPT_EXT
        send_byte(8'h01); send_byte(8'h04);
        end_bytes();
        chk_fields("optext", 5'd1, 2'd0, 2'd1, 2'd0, 32'h0);
        chk("optext_payload", 128'(bus.pkt_payload), 128'h04);
        take_pkt("optext");

        // SF_TRAP: priv decoded, no address
        send_byte(8'h01); send_byte(8'h57);
        end_bytes();
        chk_fields("trap", 5'd1, 2'd3, 2'd1, 2'd2, 32'h0);
        take_pkt("trap");

        // DIFF_DELTA: raw only
        send_byte(8'h02); send_byte(8'hFD); send_byte(8'hFF);
        end_bytes();
        chk_fields("delta", 5'd2, 2'd1, 2'd0, 2'd0, 32'h0);
        chk("delta_payload", 128'(bus.pkt_payload), 128'hFFFD);
        take_pkt("delta");

        // Oversize header: one err pulse, 20 bytes swallowed
        e0 = err_seen;
        p0 = pkt_rise;
        send_byte(8'h14);
        chk("over_err_pulse", 128'(bus.err), 128'(1));
        for (int i = 0; i < 20; i++) send_byte(8'(8'hA0 + i));
        end_bytes();
        chk("over_err_count", 128'(err_seen - e0), 128'(1));
        chk("over_no_pkt", 128'(pkt_rise - p0), 128'(0));
        chk("over_idle_ready", 128'(bus.byte_ready), 128'(1));
        send_byte(8'h01); send_byte(8'h02);
        end_bytes();
        chk_fields("after_over", 5'd1, 2'd2, 2'd0, 2'd0, 32'h0);
        take_pkt("after_over");

        // Zero-length header
        e0 = err_seen;
        send_byte(8'h00);
        chk("zero_err_pulse", 128'(bus.err), 128'(1));
        chk("zero_ready", 128'(bus.byte_ready), 128'(1));
        chk("zero_no_valid", 128'(bus.pkt_valid), 128'(0));
        send_byte(8'h01); send_byte(8'h03);
        end_bytes();
        chk("zero_err_count", 128'(err_seen - e0), 128'(1));
        chk_fields("after_zero", 5'd1, 2'd3, 2'd0, 2'd0, 32'h0);
        take_pkt("after_zero");

        // Flush mid-packet; the byte offered with flush must not be taken
        p0 = pkt_rise;
        send_byte(8'h05); send_byte(8'h11); send_byte(8'h22);
        bus.byte_data = 8'h03;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        end_bytes();
        chk("flush_no_valid", 128'(bus.pkt_valid), 128'(0));
        repeat (3) @(posedge clk);
        #1;
        chk("flush_no_pkt", 128'(pkt_rise - p0), 128'(0));
        chk("flush_ready", 128'(bus.byte_ready), 128'(1));
        // ADDR_ONLY: payload 0x001006 -> addr = 0x1006 >> 2
        send_byte(8'h03); send_byte(8'h06); send_byte(8'h10); send_byte(8'h00);
        end_bytes();
        chk_fields("after_flush", 5'd3, 2'd2, 2'd0, 2'd0, 32'h0000_0401);
        chk("after_flush_payload", 128'(bus.pkt_payload), 128'h00_1006);
        take_pkt("after_flush");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
